// File: rtl/dp_ram_b_arbiter_pkg.sv
// Shared types and helpers for the port-B arbiter/scrubber of the dual-port data RAM.
package dp_ram_b_arbiter_pkg;

  typedef enum logic {SCRUB = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic valid;
    logic id;
    logic was_write;
  } resp_t;

  localparam int DEF_RAM_DEPTH = 131072;
  localparam int WORDS         = DEF_RAM_DEPTH / 4;

  // Number of bits needed to represent value.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_b_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_q remembers the most recently granted index.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      last_q <= 1'b1;
    else if (|gnt_o) last_q <= gnt_o[1];
  end

endmodule

// File: rtl/dp_ram_b_arbiter.sv
// Port-B controller: round-robin share between core (m0) and debug/loader (m1),
// plus a zero-fill scrub sequencer run after reset or on request.
module dp_ram_b_arbiter
  import dp_ram_b_arbiter_pkg::*;
#(
  parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
  parameter int AW             = clogb2(RAM_DEPTH - 1),
  parameter bit SCRUB_ON_RESET = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scrub_req_i,
  output logic          ready_o,
  input  logic          m0_req_i,
  output logic          m0_gnt_o,
  input  logic [AW-1:0] m0_addr_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_be_i,
  input  logic [31:0]   m0_wdata_i,
  output logic          m0_rvalid_o,
  output logic [31:0]   m0_rdata_o,
  input  logic          m1_req_i,
  output logic          m1_gnt_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_be_i,
  input  logic [31:0]   m1_wdata_i,
  output logic          m1_rvalid_o,
  output logic [31:0]   m1_rdata_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i
);

  localparam int            SCRUB_WORDS = RAM_DEPTH / 4;
  localparam logic [AW-3:0] LAST_WORD   = (AW-2)'(SCRUB_WORDS - 1);
  localparam logic [AW-3:0] CNT_ONE     = (AW-2)'(1);
  localparam logic [AW-1:0] ADDR_MASK   = ~(AW'(3));
  localparam state_e        RST_STATE   = SCRUB_ON_RESET ? SCRUB : RUN;

  state_e        state_q, state_d;
  logic [AW-3:0] scrub_cnt_q, scrub_cnt_d;
  resp_t         resp_q, resp_d;
  logic [1:0]    gnt;
  logic          arb_en;

  // No grant in the cycle a scrub request is sampled.
  assign arb_en = (state_q == RUN) && !scrub_req_i;

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (arb_en),
    .req_i ({m1_req_i, m0_req_i}),
    .gnt_o (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign ready_o  = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      SCRUB: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 4'hF;
        ram_addr_o = {scrub_cnt_q, 2'b00};
        if (scrub_cnt_q == LAST_WORD) begin
          state_d     = RUN;
          scrub_cnt_d = '0;
        end else begin
          scrub_cnt_d = scrub_cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (scrub_req_i) state_d = SCRUB;
        if (gnt[0]) begin
          ram_en_o    = 1'b1;
          ram_we_o    = m0_we_i ? m0_be_i : 4'h0;
          ram_addr_o  = m0_addr_i & ADDR_MASK;
          ram_wdata_o = m0_wdata_i;
        end else if (gnt[1]) begin
          ram_en_o    = 1'b1;
          ram_we_o    = m1_we_i ? m1_be_i : 4'h0;
          ram_addr_o  = m1_addr_i & ADDR_MASK;
          ram_wdata_o = m1_wdata_i;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    resp_d.valid     = |gnt;
    resp_d.id        = gnt[1];
    resp_d.was_write = gnt[1] ? m1_we_i : m0_we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RST_STATE;
      scrub_cnt_q <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
      resp_q      <= resp_d;
    end
  end

  // Read data is forwarded straight from the RAM; writes answer with zero.
  assign m0_rvalid_o = resp_q.valid && !resp_q.id;
  assign m1_rvalid_o = resp_q.valid &&  resp_q.id;
  assign m0_rdata_o  = (m0_rvalid_o && !resp_q.was_write) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o  = (m1_rvalid_o && !resp_q.was_write) ? ram_rdata_i : 32'h0;

endmodule
